// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Optional bus timeout is enabled with LSU_TIMEOUT_EN.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } lsu_state_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } mem_size_t;

  // Size code 2'b11 has no enum member and is always rejected.
  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    is_misaligned = (size == 2'b11)
                 || ((size == SIZE_H) && off[0])
                 || ((size == SIZE_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: enables, store replication, load extract/extend.
// Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] sh;

  // Lane selection by access size; invalid size drives nothing.
  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    sh      = rdata_i >> {off_i, 3'b000};
    case (mem_size_t'(size_i))
      SIZE_B: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~uns_i & sh[7]}}, sh[7:0]};
      end
      SIZE_H: begin
        be_o    = 4'b0011 << off_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{~uns_i & sh[15]}}, sh[15:0]};
      end
      SIZE_W: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one data-bus transaction per start pulse.
// Define LSU_TIMEOUT_EN to abort stalled bus accesses.
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              we,
  input  logic [1:0]        mem_size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic              timeout_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  lsu_state_t        state_q, state_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [3:0]        be;
  logic [31:0]       wrep;
  logic [31:0]       ld_ext;
  logic              to_hit;

  lsu_lane_align u_align (
    .size_i  (size_q),
    .off_i   (addr_q[1:0]),
    .uns_i   (uns_q),
    .wdata_i (wdata_q),
    .rdata_i (bus_rdata),
    .be_o    (be),
    .wdata_o (wrep),
    .rdata_o (ld_ext)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             to_q;

  assign to_hit = ((state_q == ST_REQ) || (state_q == ST_WAIT))
               && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cycles spent on the bus; IDLE always precedes REQ so it clears here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else if (state_q == ST_IDLE)
      cnt_q <= '0;
    else if ((state_q == ST_REQ) || (state_q == ST_WAIT))
      cnt_q <= cnt_q + 1'b1;
  end

  // Remember that DONE was reached by abort; a real grant/rvalid wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      to_q <= 1'b0;
    else if (state_q == ST_IDLE)
      to_q <= 1'b0;
    else if (to_hit && (((state_q == ST_REQ) && !bus_gnt) ||
                        ((state_q == ST_WAIT) && !bus_rvalid)))
      to_q <= 1'b1;
  end

  assign timeout_err = (state_q == ST_DONE) && to_q;
`else
  logic [31:0] unused_to;
  assign unused_to   = 32'(TIMEOUT_CYCLES);
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Request capture; later start pulses are ignored while busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      we_q    <= we;
      size_q  <= mem_size;
      uns_q   <= unsigned_ld;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Load result; only read data arriving in WAIT is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rdata_q <= '0;
    else if ((state_q == ST_WAIT) && bus_rvalid)
      rdata_q <= ld_ext;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (start)
          state_d = is_misaligned(mem_size, addr[1:0]) ? ST_ERR : ST_REQ;
      ST_REQ:
        if (bus_gnt)
          state_d = we_q ? ST_DONE : ST_WAIT;
        else if (to_hit)
          state_d = ST_DONE;
      ST_WAIT:
        if (bus_rvalid || to_hit)
          state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign misalign  = (state_q == ST_ERR);
  assign rdata     = rdata_q;
  assign bus_req   = (state_q == ST_REQ);
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = bus_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_be    = bus_req ? be : 4'b0000;
  assign bus_wdata = bus_req ? wrep : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit.
// Define LSU_TIMEOUT_EN to also exercise the bus timeout.
module tb_mem_access_unit;

`ifdef LSU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, we, unsigned_ld;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;
  logic        busy, done, misalign, timeout_err;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int req_cnt = 0;
  bit req_seen = 0;

  typedef struct {
    logic        mis;
    logic        to;
    logic [31:0] rd;
    int          lat;
    int          st;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          reqs;
  } bexp_t;

  exp_t  exp_q[$];
  bexp_t bus_q[$];

  mem_access_unit #(
    .ADDR_W(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .we(we),
    .mem_size(mem_size), .unsigned_ld(unsigned_ld),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .misalign(misalign), .timeout_err(timeout_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Completion monitor.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_done: got done=1 expected none");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
        chk("timeout_err", {31'b0, timeout_err}, {31'b0, e.to});
        chk("rdata", rdata, e.rd);
        if (e.lat >= 0) chk("latency", 32'(cyc - e.st), 32'(e.lat));
      end
    end
  end

  // Bus handshake monitor.
  always @(negedge clk) begin
    if (!reset_n || !bus_req) begin
      req_cnt = 0;
    end else begin
      req_seen = 1;
      req_cnt++;
      if (bus_gnt) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_grant: got bus_req expected none");
        end else begin
          bexp_t b;
          b = bus_q.pop_front();
          chk("bus_we", {31'b0, bus_we}, {31'b0, b.we});
          chk("bus_addr", bus_addr, b.addr);
          chk("bus_be", {28'b0, bus_be}, {28'b0, b.be});
          chk("bus_wdata", bus_wdata, b.wd);
          chk("req_cycles", 32'(req_cnt), 32'(b.reqs));
        end
        req_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
  endtask

  task automatic access(
    input logic w, input logic [1:0] sz, input logic u,
    input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
    input int gd, input int rd, input bit spur, input bit nogr,
    input logic e_mis, input logic [3:0] e_be, input logic [31:0] e_wd,
    input logic [31:0] e_rd
  );
    int lat;
    if (e_mis)     lat = -1;
    else if (nogr) lat = 1 + TO;
    else if (w)    lat = 2 + gd;
    else           lat = 3 + gd + rd;
    @(posedge clk); #1;
    start = 1; we = w; mem_size = sz; unsigned_ld = u;
    addr = a; wdata = wd;
    exp_q.push_back('{mis: e_mis, to: nogr, rd: e_rd, lat: lat, st: cyc});
    if (!e_mis && !nogr)
      bus_q.push_back('{we: w, addr: {a[31:2], 2'b00}, be: e_be,
                        wd: e_wd, reqs: gd + 1});
    @(posedge clk); #1;
    start = 0;
    if (!e_mis && !nogr) begin
      for (int i = 0; i < gd; i++) begin
        if (spur && i == 0) begin
          start = 1; we = 1; addr = 32'hDEAD_0000; mem_size = 2'b10;
        end
        if (spur && i == 1) begin
          bus_rvalid = 1; bus_rdata = 32'hFFFF_FFFF;
        end
        @(posedge clk); #1;
        start = 0; bus_rvalid = 0;
      end
      bus_gnt = 1;
      @(posedge clk); #1;
      bus_gnt = 0;
      if (!w) begin
        for (int i = 0; i < rd; i++) begin
          @(posedge clk); #1;
        end
        bus_rvalid = 1; bus_rdata = rw;
        @(posedge clk); #1;
        bus_rvalid = 0; bus_rdata = 32'h5A5A_5A5A;
      end
    end
    wait_idle();
  endtask

  initial begin
    reset_n = 0; start = 0; we = 0; mem_size = 0; unsigned_ld = 0;
    addr = 0; wdata = 0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {23'b0, busy, done, misalign, timeout_err,
                    bus_req, bus_we, bus_be[2:0]}, 32'h0);
    chk("rst_be", {28'b0, bus_be}, 32'h0);
    chk("rst_data", rdata | bus_wdata | bus_addr, 32'h0);
    reset_n = 1;

    // store byte, zero-wait
    access(1, 2'b00, 0, 32'h103, 32'hAABB_CCDD, 0, 0, 0, 0, 0,
           0, 4'b1000, 32'hDDDD_DDDD, 32'h0);
    // load half signed / unsigned
    access(0, 2'b01, 0, 32'h202, 0, 32'h8001_1234, 0, 0, 0, 0,
           0, 4'b1100, 32'h0, 32'hFFFF_8001);
    access(0, 2'b01, 1, 32'h202, 0, 32'h8001_1234, 0, 0, 0, 0,
           0, 4'b1100, 32'h0, 32'h0000_8001);
    // misaligned word, then invalid size
    req_seen = 0;
    access(0, 2'b10, 0, 32'h301, 0, 0, 0, 0, 0, 0,
           1, 4'b0000, 32'h0, 32'h0000_8001);
    access(0, 2'b11, 0, 32'h800, 0, 0, 0, 0, 0, 0,
           1, 4'b0000, 32'h0, 32'h0000_8001);
    chk("no_req_on_err", {31'b0, req_seen}, 32'h0);
    // byte loads at lanes 1 and 3
    access(0, 2'b00, 0, 32'h401, 0, 32'h0000_F700, 0, 0, 0, 0,
           0, 4'b0010, 32'h0, 32'hFFFF_FFF7);
    access(0, 2'b00, 1, 32'hD03, 0, 32'h80FF_FFFF, 0, 0, 0, 0,
           0, 4'b1000, 32'h0, 32'h0000_0080);
    // half and word stores
    access(1, 2'b01, 0, 32'h602, 32'h1122_3344, 0, 1, 0, 0, 0,
           0, 4'b1100, 32'h3344_3344, 32'h0000_0080);
    access(1, 2'b10, 0, 32'h700, 32'hCAFE_F00D, 0, 0, 0, 0, 0,
           0, 4'b1111, 32'hCAFE_F00D, 32'h0000_0080);
    // slow grant and rvalid, with a start and rvalid while busy
    access(0, 2'b10, 0, 32'h900, 0, 32'h8765_4321, 3, 1, 1, 0,
           0, 4'b1111, 32'h0, 32'h8765_4321);

    // reset while waiting for read data
    @(posedge clk); #1;
    start = 1; we = 0; mem_size = 2'b00; unsigned_ld = 1;
    addr = 32'hA03; wdata = 0;
    bus_q.push_back('{we: 0, addr: 32'hA00, be: 4'b1000,
                      wd: 32'h0, reqs: 1});
    @(posedge clk); #1;
    start = 0; bus_gnt = 1;
    @(posedge clk); #1;
    bus_gnt = 0;
    chk("wait_busy", {31'b0, busy}, 32'h1);
    reset_n = 0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_req", {31'b0, bus_req}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", {30'b0, busy, done}, 32'h0);
    access(0, 2'b01, 1, 32'hB00, 0, 32'h0000_FFFE, 0, 0, 0, 0,
           0, 4'b0011, 32'h0, 32'h0000_FFFE);

`ifdef LSU_TIMEOUT_EN
    access(0, 2'b10, 0, 32'hC00, 0, 0, 0, 0, 0, 1,
           0, 4'b1111, 32'h0, 32'h0000_FFFE);
    chk("to_req_low", {31'b0, bus_req}, 32'h0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("done_q_empty", 32'(exp_q.size()), 32'h0);
    chk("bus_q_empty", 32'(bus_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
